// File: rtl/vcve2_vec_elem_seq.sv
// Vector element sequencer: walks the active 32-bit words of a vector op between RF and EX.
// Optional perf counters are built when VCVE2_VEC_SEQ_PERF_EN is defined.
module vcve2_vec_elem_seq #(
  parameter  int VLEN   = 128,
  localparam int WORDS  = VLEN / 32,
  localparam int WIDX_W = $clog2(WORDS),
  localparam int AW     = 5 + WIDX_W,
  localparam int VL_W   = $clog2(VLEN / 8) + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  output logic            ready_o,
  input  logic            kill_i,
  input  logic [VL_W-1:0] vl_i,
  input  logic [2:0]      vsew_i,
  input  logic [4:0]      vs1_i,
  input  logic [4:0]      vs2_i,
  input  logic [4:0]      vd_i,
  output logic [AW-1:0]   rf_raddr_a_o,
  output logic [AW-1:0]   rf_raddr_b_o,
  output logic [AW-1:0]   rf_raddr_c_o,
  input  logic [31:0]     rf_rdata_a_i,
  input  logic [31:0]     rf_rdata_b_i,
  input  logic [31:0]     rf_rdata_c_i,
  output logic [31:0]     ex_operand_a_o,
  output logic [31:0]     ex_operand_b_o,
  output logic [31:0]     ex_operand_c_o,
  output logic [2:0]      ex_vsew_o,
  output logic            ex_first_cycle_o,
  input  logic            ex_valid_i,
  input  logic [31:0]     ex_result_i,
  output logic            rf_we_o,
  output logic [AW-1:0]   rf_waddr_o,
  output logic [3:0]      rf_be_o,
  output logic [31:0]     rf_wdata_o,
  output logic            done_o
`ifdef VCVE2_VEC_SEQ_PERF_EN
  ,
  output logic [31:0]     perf_busy_cycles_o,
  output logic [31:0]     perf_ex_stall_o
`endif
);

  localparam int BW = VL_W + 2;
  localparam logic [BW-1:0] MAX_B = BW'(VLEN / 8);

  typedef enum logic [2:0] {
    IDLE, RD, EXE, WB, DONE
  } state_e;

  state_e state_q, state_d;
  logic cap_q, cap_d;
  logic first_q, first_d;
  logic [WIDX_W-1:0] widx_q, widx_d;
  logic [WIDX_W-1:0] last_q, last_d;
  logic [1:0] tail_q, tail_d;
  logic [2:0] vsew_q, vsew_d;
  logic [4:0] vs1_q, vs1_d;
  logic [4:0] vs2_q, vs2_d;
  logic [4:0] vd_q, vd_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [31:0] opc_q, opc_d;
  logic [31:0] wdata_q, wdata_d;

  logic [1:0] sew_log2;
  logic [BW-1:0] bytes_raw, bytes_c, nw_c;
  logic abort, is_last;

  always_comb begin
    unique case (vsew_i)
      3'd0:    sew_log2 = 2'd0;
      3'd1:    sew_log2 = 2'd1;
      default: sew_log2 = 2'd2;
    endcase
    bytes_raw = BW'(vl_i) << sew_log2;
    bytes_c   = (bytes_raw > MAX_B) ? MAX_B : bytes_raw;
    nw_c      = (bytes_c + BW'(3)) >> 2;
  end

  assign abort   = kill_i | rst_i;
  assign is_last = (widx_q == last_q);

  always_comb begin
    state_d = state_q;
    cap_d   = 1'b0;
    first_d = 1'b0;
    widx_d  = widx_q;
    last_d  = last_q;
    tail_d  = tail_q;
    vsew_d  = vsew_q;
    vs1_d   = vs1_q;
    vs2_d   = vs2_q;
    vd_d    = vd_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    opc_d   = opc_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          vsew_d  = vsew_i;
          vs1_d   = vs1_i;
          vs2_d   = vs2_i;
          vd_d    = vd_i;
          last_d  = WIDX_W'(nw_c - BW'(1));
          tail_d  = bytes_c[1:0];
          widx_d  = '0;
          state_d = (nw_c == '0) ? DONE : RD;
        end
      end
      RD: begin
        // Two cycles: address out, then capture the RF's registered data.
        if (!cap_q) begin
          cap_d = 1'b1;
        end else begin
          opa_d   = rf_rdata_a_i;
          opb_d   = rf_rdata_b_i;
          opc_d   = rf_rdata_c_i;
          first_d = 1'b1;
          state_d = EXE;
        end
      end
      EXE: begin
        if (ex_valid_i) begin
          wdata_d = ex_result_i;
          state_d = WB;
        end
      end
      WB: begin
        if (is_last) begin
          state_d = DONE;
        end else begin
          widx_d  = widx_q + WIDX_W'(1);
          state_d = RD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (kill_i) begin
      state_d = IDLE;
      cap_d   = 1'b0;
      first_d = 1'b0;
      widx_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cap_q   <= 1'b0;
      first_q <= 1'b0;
      widx_q  <= '0;
      last_q  <= '0;
      tail_q  <= '0;
      vsew_q  <= '0;
      vs1_q   <= '0;
      vs2_q   <= '0;
      vd_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      opc_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      first_q <= first_d;
      widx_q  <= widx_d;
      last_q  <= last_d;
      tail_q  <= tail_d;
      vsew_q  <= vsew_d;
      vs1_q   <= vs1_d;
      vs2_q   <= vs2_d;
      vd_q    <= vd_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      opc_q   <= opc_d;
      wdata_q <= wdata_d;
    end
  end

  assign ready_o          = (state_q == IDLE);
  assign done_o           = (state_q == DONE) && !abort;
  assign rf_we_o          = (state_q == WB) && !abort;
  assign rf_raddr_a_o     = (state_q == RD) ? {vs1_q, widx_q} : '0;
  assign rf_raddr_b_o     = (state_q == RD) ? {vs2_q, widx_q} : '0;
  assign rf_raddr_c_o     = (state_q == RD) ? {vd_q, widx_q} : '0;
  assign rf_waddr_o       = (state_q == WB) ? {vd_q, widx_q} : '0;
  assign rf_wdata_o       = wdata_q;
  assign ex_operand_a_o   = opa_q;
  assign ex_operand_b_o   = opb_q;
  assign ex_operand_c_o   = opc_q;
  assign ex_vsew_o        = vsew_q;
  assign ex_first_cycle_o = first_q;

  always_comb begin
    rf_be_o = 4'h0;
    if (state_q == WB) begin
      rf_be_o = 4'hF;
      if (is_last) begin
        unique case (tail_q)
          2'd1:    rf_be_o = 4'h1;
          2'd2:    rf_be_o = 4'h3;
          2'd3:    rf_be_o = 4'h7;
          default: rf_be_o = 4'hF;
        endcase
      end
    end
  end

`ifdef VCVE2_VEC_SEQ_PERF_EN
  logic [31:0] busy_q, busy_d;
  logic [31:0] stall_q, stall_d;

  always_comb begin
    busy_d  = busy_q;
    stall_d = stall_q;
    if (state_q != IDLE && busy_q != 32'hFFFF_FFFF) begin
      busy_d = busy_q + 32'd1;
    end
    if (state_q == EXE && !ex_valid_i && stall_q != 32'hFFFF_FFFF) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q  <= '0;
      stall_q <= '0;
    end else begin
      busy_q  <= busy_d;
      stall_q <= stall_d;
    end
  end

  assign perf_busy_cycles_o = busy_q;
  assign perf_ex_stall_o    = stall_q;
`endif

endmodule

// File: tb/tb_vcve2_vec_elem_seq.sv
// Scoreboard bench for vcve2_vec_elem_seq: RF and EX models, directed plus random ops.
// Expected writes and done timing come from a byte/word arithmetic model.
module tb_vcve2_vec_elem_seq;
  localparam int VLEN   = 128;
  localparam int WORDS  = VLEN / 32;
  localparam int WIDX_W = $clog2(WORDS);
  localparam int AW     = 5 + WIDX_W;
  localparam int VL_W   = $clog2(VLEN / 8) + 1;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            start_i;
  logic            ready_o;
  logic            kill_i;
  logic [VL_W-1:0] vl_i;
  logic [2:0]      vsew_i;
  logic [4:0]      vs1_i, vs2_i, vd_i;
  logic [AW-1:0]   rf_raddr_a_o, rf_raddr_b_o, rf_raddr_c_o;
  logic [31:0]     rf_rdata_a_i, rf_rdata_b_i, rf_rdata_c_i;
  logic [31:0]     ex_operand_a_o, ex_operand_b_o, ex_operand_c_o;
  logic [2:0]      ex_vsew_o;
  logic            ex_first_cycle_o;
  logic            ex_valid_i;
  logic [31:0]     ex_result_i;
  logic            rf_we_o;
  logic [AW-1:0]   rf_waddr_o;
  logic [3:0]      rf_be_o;
  logic [31:0]     rf_wdata_o;
  logic            done_o;
`ifdef VCVE2_VEC_SEQ_PERF_EN
  logic [31:0]     perf_busy;
  logic [31:0]     perf_stall;
`endif

  vcve2_vec_elem_seq #(.VLEN(VLEN)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .start_i(start_i), .ready_o(ready_o), .kill_i(kill_i),
    .vl_i(vl_i), .vsew_i(vsew_i),
    .vs1_i(vs1_i), .vs2_i(vs2_i), .vd_i(vd_i),
    .rf_raddr_a_o(rf_raddr_a_o), .rf_raddr_b_o(rf_raddr_b_o),
    .rf_raddr_c_o(rf_raddr_c_o),
    .rf_rdata_a_i(rf_rdata_a_i), .rf_rdata_b_i(rf_rdata_b_i),
    .rf_rdata_c_i(rf_rdata_c_i),
    .ex_operand_a_o(ex_operand_a_o), .ex_operand_b_o(ex_operand_b_o),
    .ex_operand_c_o(ex_operand_c_o),
    .ex_vsew_o(ex_vsew_o), .ex_first_cycle_o(ex_first_cycle_o),
    .ex_valid_i(ex_valid_i), .ex_result_i(ex_result_i),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_be_o(rf_be_o),
    .rf_wdata_o(rf_wdata_o), .done_o(done_o)
`ifdef VCVE2_VEC_SEQ_PERF_EN
    , .perf_busy_cycles_o(perf_busy), .perf_ex_stall_o(perf_stall)
`endif
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [3:0]    be;
    logic [31:0]   data;
  } wr_t;

  wr_t         exp_q[$];
  int          done_q[$];
  wr_t         mon_e;
  logic [31:0] rf [32*WORDS];
  int          lat_tab [WORDS];
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  int          done_seen = 0;
  int          ex_cnt = 0;
  logic [31:0] sa, sb, sc;

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(posedge clk_i) begin
    rf_rdata_a_i <= rf[rf_raddr_a_o];
    rf_rdata_b_i <= rf[rf_raddr_b_o];
    rf_rdata_c_i <= rf[rf_raddr_c_o];
  end

  function automatic logic [31:0] ex_fn(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic [31:0] c);
    return (a + b) ^ {c[15:0], c[31:16]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT writes or finishes.
  always @(negedge clk_i) begin
    if (rf_we_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("write_unexpected", 64'(rf_we_o), 64'(0));
      end else begin
        mon_e = exp_q.pop_front();
        chk("write", 64'({rf_waddr_o, rf_be_o, rf_wdata_o}),
            64'({mon_e.addr, mon_e.be, mon_e.data}));
      end
    end
    if (done_o === 1'b1) begin
      done_seen++;
      if (done_q.size() == 0) chk("done_unexpected", 64'(done_o), 64'(0));
      else chk("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
    end
  end

  // EX model: variable latency per word, checks operands hold meanwhile.
  initial begin
    int lat;
    ex_valid_i  = 1'b0;
    ex_result_i = '0;
    forever begin
      @(posedge clk_i); #1;
      ex_valid_i = 1'b0;
      if (ex_first_cycle_o === 1'b1) begin
        sa  = ex_operand_a_o;
        sb  = ex_operand_b_o;
        sc  = ex_operand_c_o;
        lat = lat_tab[ex_cnt % WORDS];
        ex_cnt++;
        for (int i = 0; i < lat; i++) begin
          @(posedge clk_i); #1;
          chk("operands_stable",
              64'({ex_operand_a_o == sa, ex_operand_b_o == sb,
                   ex_operand_c_o == sc}), 64'(3'b111));
        end
        ex_valid_i  = 1'b1;
        ex_result_i = ex_fn(sa, sb, sc);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 64'(ready_o), 64'(1));
    chk({tag, "_done"}, 64'(done_o), 64'(0));
    chk({tag, "_we"}, 64'(rf_we_o), 64'(0));
    chk({tag, "_first"}, 64'(ex_first_cycle_o), 64'(0));
    chk({tag, "_raddr"},
        64'({rf_raddr_a_o, rf_raddr_b_o, rf_raddr_c_o}), 64'(0));
    chk({tag, "_waddr_be"}, 64'({rf_waddr_o, rf_be_o}), 64'(0));
    chk({tag, "_opab"}, {ex_operand_a_o, ex_operand_b_o}, 64'(0));
    chk({tag, "_opc_wdata"}, {ex_operand_c_o, rf_wdata_o}, 64'(0));
    chk({tag, "_vsew"}, 64'(ex_vsew_o), 64'(0));
  endtask

  task automatic run_op(input int vl, input int sew, input int v1,
                        input int v2, input int vd,
                        input int kill_w, input int rst_w);
    int  sl, bytes, nw, t, edone, cnt, d0;
    bit  abrt;
    wr_t e;
    t = 0;
    while (ready_o !== 1'b1 && t < 100) begin
      @(posedge clk_i); #1;
      t++;
    end
    chk("ready_before_start", 64'(ready_o), 64'(1));
    sl    = (sew == 0) ? 0 : (sew == 1) ? 1 : 2;
    bytes = vl * (1 << sl);
    if (bytes > VLEN / 8) bytes = VLEN / 8;
    nw    = (bytes + 3) / 4;
    abrt  = (kill_w >= 0) || (rst_w >= 0);
    edone = cyc + 1;
    for (int w = 0; w < nw; w++) begin
      edone += 4 + lat_tab[w];
      if ((kill_w < 0 || w < kill_w) && (rst_w < 0 || w < rst_w)) begin
        e.addr = AW'(vd * WORDS + w);
        e.be   = (w == nw - 1 && bytes % 4 != 0) ?
                 4'((1 << (bytes % 4)) - 1) : 4'hF;
        e.data = ex_fn(rf[v1*WORDS+w], rf[v2*WORDS+w], rf[vd*WORDS+w]);
        exp_q.push_back(e);
      end
    end
    if (!abrt) done_q.push_back(edone);
    d0      = done_seen;
    vl_i    = VL_W'(vl);
    vsew_i  = 3'(sew);
    vs1_i   = 5'(v1);
    vs2_i   = 5'(v2);
    vd_i    = 5'(vd);
    ex_cnt  = 0;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    if (abrt) begin
      cnt = 0;
      t   = 0;
      while (t < 200) begin
        if (kill_w >= 0 && ex_first_cycle_o === 1'b1) begin
          if (cnt == kill_w) begin
            kill_i = 1'b1;
            break;
          end
          cnt++;
        end
        if (rst_w >= 0 && rf_we_o === 1'b1) begin
          if (cnt == rst_w) begin
            rst_i = 1'b1;
            break;
          end
          cnt++;
        end
        @(posedge clk_i); #1;
        t++;
      end
      chk("abort_point_reached", 64'(kill_i | rst_i), 64'(1));
      @(posedge clk_i); #1;
      if (rst_i) begin
        check_reset_outputs("post_rst");
      end else begin
        chk("ready_after_kill", 64'(ready_o), 64'(1));
        chk("we_after_kill", 64'(rf_we_o), 64'(0));
      end
      kill_i = 1'b0;
      rst_i  = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
    end else begin
      t = 0;
      while (done_seen == d0 && t < 300) begin
        @(posedge clk_i); #1;
        t++;
      end
      chk("done_seen", 64'(done_seen - d0), 64'(1));
    end
  endtask

  task automatic set_lat(input int l0, input int l1,
                         input int l2, input int l3);
    lat_tab[0] = l0;
    lat_tab[1] = l1;
    lat_tab[2] = l2;
    lat_tab[3] = l3;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef VCVE2_VEC_SEQ_PERF_EN
    logic [31:0] stall0;
`endif
    foreach (rf[i]) rf[i] = $urandom;
    set_lat(0, 0, 0, 0);
    rst_i   = 1'b1;
    start_i = 1'b0;
    kill_i  = 1'b0;
    vl_i    = '0;
    vsew_i  = '0;
    vs1_i   = '0;
    vs2_i   = '0;
    vd_i    = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check_reset_outputs("reset");
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    run_op(4, 2, 1, 2, 3, -1, -1);
    run_op(6, 0, 4, 5, 6, -1, -1);
    run_op(0, 1, 7, 8, 9, -1, -1);
    set_lat(0, 3, 0, 0);
`ifdef VCVE2_VEC_SEQ_PERF_EN
    stall0 = perf_stall;
`endif
    run_op(31, 1, 10, 11, 12, -1, -1);
`ifdef VCVE2_VEC_SEQ_PERF_EN
    chk("perf_stall_delta", 64'(perf_stall - stall0), 64'(3));
`endif
    set_lat(0, 0, 0, 0);
    run_op(4, 2, 13, 14, 15, 2, -1);
    run_op(4, 2, 16, 17, 18, -1, -1);
    run_op(4, 2, 19, 20, 21, -1, 1);
    run_op(3, 5, 22, 23, 24, -1, -1);

    for (int n = 0; n < 25; n++) begin
      foreach (lat_tab[i]) lat_tab[i] = $urandom_range(0, 2);
      run_op($urandom_range(0, 31), $urandom_range(0, 7),
             $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), -1, -1);
    end

    repeat (10) @(posedge clk_i);
    #1;
    chk("writes_outstanding", 64'(exp_q.size()), 64'(0));
    chk("dones_outstanding", 64'(done_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
